nios_custom_dma_read_master: RTL and testbench
==============================================

// Module: nios_custom_dma_read_master
// PURPOSE
//  Avalon-MM pipelined read master: the initiator side of the DMA source-RAM slave (32-bit, 1-cycle read latency).
//  Reads a block of words starting at a programmed byte address into an internal FIFO.
//  Streams the words out on an Avalon-ST source with SOP/EOP framing.
//  Sits between the source RAM and the DMA write path; controlled by the DMA CSR block.
// PARAMETERS
//  DATA_W      32   data width (bits); byteenable = all ones, DATA_W/8 bits
//  ADDR_W      32   byte address width; address wraps modulo 2^ADDR_W
//  LEN_W       16   transfer length width, in words
//  FIFO_DEPTH  16   response FIFO depth, in words; power of 2
//  FIFO_AW     4    log2(FIFO_DEPTH)
// PORTS
//  clk             in   1         single clock
//  reset           in   1         synchronous, active-high
//  ctrl_start      in   1         1-cycle request; samples ctrl_src_addr and ctrl_len_words
//  ctrl_src_addr   in   ADDR_W    start byte address; bits [1:0] forced to 0
//  ctrl_len_words  in   LEN_W     number of words to read
//  ctrl_busy       out  1         transfer in progress
//  ctrl_done       out  1         1-cycle pulse at end of transfer
//  m_address       out  ADDR_W    Avalon-MM byte address
//  m_read          out  1         Avalon-MM read request
//  m_byteenable    out  DATA_W/8  constant all ones
//  m_waitrequest   in   1         slave stall
//  m_readdata      in   DATA_W    read response data
//  m_readdatavalid in   1         response valid
//  st_data         out  DATA_W    stream data (FIFO head)
//  st_valid        out  1         stream valid
//  st_ready        in   1         stream ready; beat transfers when valid & ready
//  st_sop          out  1         first word of transfer
//  st_eop          out  1         last word of transfer
// BEHAVIOUR
//  Reset values: m_read=0, m_address=0, ctrl_busy=0, ctrl_done=0, st_valid=0, st_sop=0, st_eop=0.
//   Reset also empties the FIFO and clears all counters.
//  FSM IDLE -> READ -> DRAIN -> IDLE.
//  IDLE:
//   - start with len!=0: latch address and length; go to READ; ctrl_busy=1 from the next cycle.
//   - start with len==0: no bus activity; ctrl_done pulses the next cycle; stay in IDLE.
//  start while busy: ignored.
//  READ:
//   - m_read=1 while issue_left>0 and (outstanding + fifo_count) < FIFO_DEPTH (credit rule).
//   - Accept = m_read & ~m_waitrequest. On accept: m_address += 4, issue_left--, outstanding++.
//   - While stalled, m_read and m_address hold stable.
//   - Enter DRAIN on the cycle the last read is accepted.
//  DRAIN: wait for outstanding==0 and the last beat (EOP) to be consumed.
//   - Then go to IDLE, pulse ctrl_done, drop ctrl_busy the same cycle.
//  Responses: each m_readdatavalid writes m_readdata into the FIFO and decrements outstanding.
//   - The credit rule guarantees no overflow.
//   - m_readdatavalid in IDLE is dropped.
//  FIFO: registered write; st_valid = ~empty; st_data = head (fall-through).
//   - Simultaneous push and pop leaves the count unchanged.
//  st_sop on beat 0; st_eop on beat len-1 (beat counter); both are qualified by st_valid.
//  Latency, zero-wait slave, st_ready=1:
//   - start @0, m_read @1, readdatavalid @2, st_valid @3.
//   - Throughput 1 word/cycle.
//  Reset mid-transfer: abort immediately; no ctrl_done; late responses are dropped.
// TESTING
//  T1: addr 0x100, len 4, RAM[0x40..0x43]=A,B,C,D, ready=1
//      -> reads 0x100,0x104,0x108,0x10C; st A,B,C,D; sop on A, eop on D; one done pulse.
//  T2: len 32, st_ready=0 -> exactly 16 accepted reads, then m_read=0;
//      ready=1 -> all 32 words in order, none lost or duplicated.
//  T3: len 16 with random 50% waitrequest -> address/read stable during stalls; addresses strictly +4; data in order.
//  T4: len 0 -> m_read never asserted; ctrl_done one cycle after start; busy stays 0.
//  T5: start during busy -> ignored. Reset at beat 5 of 10 -> reset values next cycle;
//      a late readdatavalid is not delivered; a new len 2 transfer completes correctly.
//  T6: addr 0xFFFFFFF8, len 4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/nios_custom_dma_read_master_if.sv
// rtl/nios_custom_dma_read_master_if.sv - control, Avalon-MM read and Avalon-ST source signals of the DMA read master
interface nios_custom_dma_read_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic                  ctrl_start;
    logic [ADDR_W-1:0]     ctrl_src_addr;
    logic [LEN_W-1:0]      ctrl_len_words;
    logic                  ctrl_busy;
    logic                  ctrl_done;

    logic [ADDR_W-1:0]     m_address;
    logic                  m_read;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_waitrequest;
    logic [DATA_W-1:0]     m_readdata;
    logic                  m_readdatavalid;

    logic [DATA_W-1:0]     st_data;
    logic                  st_valid;
    logic                  st_ready;
    logic                  st_sop;
    logic                  st_eop;

    modport master (
        input  ctrl_start, ctrl_src_addr, ctrl_len_words,
        input  m_waitrequest, m_readdata, m_readdatavalid, st_ready,
        output ctrl_busy, ctrl_done, m_address, m_read, m_byteenable,
        output st_data, st_valid, st_sop, st_eop
    );

    modport slave (
        output ctrl_start, ctrl_src_addr, ctrl_len_words,
        output m_waitrequest, m_readdata, m_readdatavalid, st_ready,
        input  ctrl_busy, ctrl_done, m_address, m_read, m_byteenable,
        input  st_data, st_valid, st_sop, st_eop
    );
endinterface

// File: rtl/nios_custom_dma_read_master.sv
// rtl/nios_custom_dma_read_master.sv - pipelined Avalon-MM block reader feeding a framed Avalon-ST source via a credit-limited FIFO
module nios_custom_dma_read_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic clk,
    input  logic reset,
    nios_custom_dma_read_master_if.master bus
);
    localparam int CW = FIFO_AW + 1;
    localparam int SW = FIFO_AW + 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  beat_cnt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              done_q;

    logic start_ok, start_run, start_zero;
    logic credit_ok, issue, accept, push, pop, finished;

    assign start_ok   = bus.ctrl_start && (state_q == S_IDLE);
    assign start_run  = start_ok && (bus.ctrl_len_words != '0);
    assign start_zero = start_ok && (bus.ctrl_len_words == '0);

    // Reads in flight plus words already buffered may never exceed the FIFO,
    // so responses can always be accepted without backpressure.
    assign credit_ok = (SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
    assign issue     = (state_q == S_READ) && (issue_left != '0) && credit_ok;
    assign accept    = issue && !bus.m_waitrequest;
    assign push      = bus.m_readdatavalid && (state_q != S_IDLE);
    assign pop       = bus.st_valid && bus.st_ready;
    assign finished  = (state_q == S_DRAIN) && (outstanding == '0) && (beat_cnt == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_run) state_d = S_READ;
            S_READ:  if (accept && (issue_left == LEN_W'(1))) state_d = S_DRAIN;
            S_DRAIN: if (finished) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_left  <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finished || start_zero;

            if (start_run) begin
                addr_q     <= {bus.ctrl_src_addr[ADDR_W-1:2], 2'b00};
                len_q      <= bus.ctrl_len_words;
                issue_left <= bus.ctrl_len_words;
                beat_cnt   <= '0;
            end else if (accept) begin
                addr_q     <= addr_q + ADDR_W'(4);
                issue_left <= issue_left - LEN_W'(1);
            end

            outstanding <= outstanding + CW'(accept) - CW'(push);

            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + FIFO_AW'(1);
                beat_cnt <= beat_cnt + LEN_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.m_readdata;
    end

    assign bus.ctrl_busy    = (state_q != S_IDLE);
    assign bus.ctrl_done    = done_q;
    assign bus.m_address    = addr_q;
    assign bus.m_read       = issue;
    assign bus.m_byteenable = '1;
    assign bus.st_valid     = (fifo_count != '0);
    assign bus.st_data      = mem[rd_ptr];
    assign bus.st_sop       = bus.st_valid && (beat_cnt == '0);
    assign bus.st_eop       = bus.st_valid && (beat_cnt == len_q - LEN_W'(1));
endmodule

// File: tb/tb_nios_custom_dma_read_master.sv
// tb/tb_nios_custom_dma_read_master.sv - directed self-checking bench for nios_custom_dma_read_master
module tb_nios_custom_dma_read_master;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios_custom_dma_read_master_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) bus ();

    nios_custom_dma_read_master #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(16), .FIFO_DEPTH(16), .FIFO_AW(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source RAM: one-cycle read latency, optional random waitrequest
    logic [31:0] ram [1024];
    logic        wr_rand = 1'b0;
    logic        s_acc = 1'b0;
    logic [31:0] s_addr = '0;

    always @(negedge clk) begin
        s_acc  = bus.m_read && !bus.m_waitrequest;
        s_addr = bus.m_address;
    end

    always @(posedge clk) begin
        #1;
        bus.m_readdatavalid = s_acc;
        bus.m_readdata      = s_acc ? ram[s_addr[11:2]] : 32'hDEAD_BEEF;
        bus.m_waitrequest   = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: everything observed at negedge, cleared when an idle start is seen
    logic [31:0] acc_addr [$];
    logic [31:0] got_data [$];
    logic        got_sop  [$];
    logic        got_eop  [$];
    int start_cyc = 0, first_read = -1, first_rdv = -1, first_stv = -1;
    int first_beat = -1, last_beat = -1, done_cyc = -1;
    int nreads = 0, busy_seen = 0, done_cnt = 0, stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ctrl_start && !bus.ctrl_busy) begin
                acc_addr.delete(); got_data.delete(); got_sop.delete(); got_eop.delete();
                start_cyc = cyc; first_read = -1; first_rdv = -1; first_stv = -1;
                first_beat = -1; last_beat = -1; done_cyc = -1; nreads = 0; busy_seen = 0;
            end
            if (bus.m_read) begin
                nreads++;
                if (first_read < 0) first_read = cyc - start_cyc;
            end
            if (bus.m_read && !bus.m_waitrequest) acc_addr.push_back(bus.m_address);
            if (prev_stall && (!bus.m_read || bus.m_address != prev_addr)) stall_err++;
            prev_stall = bus.m_read && bus.m_waitrequest;
            prev_addr  = bus.m_address;
            if (bus.m_readdatavalid && first_rdv < 0) first_rdv = cyc - start_cyc;
            if (bus.st_valid && first_stv < 0) first_stv = cyc - start_cyc;
            if (bus.st_valid && bus.st_ready) begin
                got_data.push_back(bus.st_data);
                got_sop.push_back(bus.st_sop);
                got_eop.push_back(bus.st_eop);
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            if (bus.ctrl_done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
            if (bus.ctrl_busy) busy_seen++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int done_base = 0;

    task automatic start_xfer(input logic [31:0] addr, input logic [15:0] len);
        done_base = done_cnt;
        @(posedge clk); #1;
        bus.ctrl_start     = 1'b1;
        bus.ctrl_src_addr  = addr;
        bus.ctrl_len_words = len;
        @(posedge clk); #1;
        bus.ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == done_base && n < 300) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
        repeat (4) @(posedge clk);
        check_eq({tag, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
    endtask

    task automatic verify(input string tag, input logic [31:0] base, input int len);
        logic [31:0] a;
        check_eq({tag, "_nreads"}, 64'(acc_addr.size()), 64'(len));
        check_eq({tag, "_nbeats"}, 64'(got_data.size()), 64'(len));
        for (int i = 0; i < len; i++) begin
            a = base + 32'(4 * i);
            if (i < acc_addr.size())
                check_eq($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[i]), 64'(a));
            if (i < got_data.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(ram[a[11:2]]));
                check_eq($sformatf("%s_sop%0d", tag, i), 64'(got_sop[i]), 64'(i == 0));
                check_eq($sformatf("%s_eop%0d", tag, i), 64'(got_eop[i]), 64'(i == len - 1));
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_m_read"}, 64'(bus.m_read), 64'd0);
        check_eq({tag, "_m_address"}, 64'(bus.m_address), 64'd0);
        check_eq({tag, "_busy"}, 64'(bus.ctrl_busy), 64'd0);
        check_eq({tag, "_done"}, 64'(bus.ctrl_done), 64'd0);
        check_eq({tag, "_st_valid"}, 64'(bus.st_valid), 64'd0);
        check_eq({tag, "_sop_eop"}, 64'({bus.st_sop, bus.st_eop}), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
        ram[10'h040] = 32'h0000_000A;
        ram[10'h041] = 32'h0000_000B;
        ram[10'h042] = 32'h0000_000C;
        ram[10'h043] = 32'h0000_000D;
        reset = 1'b1;
        bus.ctrl_start = 1'b0; bus.ctrl_src_addr = '0; bus.ctrl_len_words = '0;
        bus.st_ready = 1'b1; bus.m_waitrequest = 1'b0;
        bus.m_readdatavalid = 1'b0; bus.m_readdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1 reset = 1'b0;

        // T1: basic block of four with latency and throughput
        start_xfer(32'h0000_0100, 16'd4);
        wait_done("t1");
        check_eq("t1_addr0", 64'(acc_addr[0]), 64'h100);
        check_eq("t1_addr3", 64'(acc_addr[3]), 64'h10C);
        check_eq("t1_data0", 64'(got_data[0]), 64'hA);
        check_eq("t1_data3", 64'(got_data[3]), 64'hD);
        verify("t1", 32'h0000_0100, 4);
        check_eq("t1_lat_read", 64'(first_read), 64'd1);
        check_eq("t1_lat_rdv", 64'(first_rdv), 64'd2);
        check_eq("t1_lat_stv", 64'(first_stv), 64'd3);
        check_eq("t1_throughput", 64'(last_beat - first_beat), 64'd3);

        // T2: stream stalled, credit limit caps outstanding reads at the FIFO depth
        bus.st_ready = 1'b0;
        start_xfer(32'h0000_0400, 16'd32);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("t2_credit_reads", 64'(acc_addr.size()), 64'd16);
        check_eq("t2_read_low", 64'(bus.m_read), 64'd0);
        @(posedge clk); #1 bus.st_ready = 1'b1;
        wait_done("t2");
        verify("t2", 32'h0000_0400, 32);

        // T3: random waitrequest
        wr_rand = 1'b1;
        start_xfer(32'h0000_0200, 16'd16);
        wait_done("t3");
        wr_rand = 1'b0;
        check_eq("t3_stall_stable", 64'(stall_err), 64'd0);
        verify("t3", 32'h0000_0200, 16);

        // T4: zero length
        start_xfer(32'h0000_0300, 16'd0);
        repeat (5) @(posedge clk);
        check_eq("t4_no_read", 64'(nreads), 64'd0);
        check_eq("t4_done_lat", 64'(done_cyc), 64'd1);
        check_eq("t4_done_count", 64'(done_cnt - done_base), 64'd1);
        check_eq("t4_busy", 64'(busy_seen), 64'd0);

        // T5a: start while busy is ignored
        start_xfer(32'h0000_0500, 16'd4);
        bus.ctrl_start = 1'b1; bus.ctrl_src_addr = 32'h600; bus.ctrl_len_words = 16'd2;
        @(posedge clk); #1 bus.ctrl_start = 1'b0;
        wait_done("t5a");
        verify("t5a", 32'h0000_0500, 4);

        // T5b: reset at beat 5 of 10
        start_xfer(32'h0000_0700, 16'd10);
        n = 0;
        while (got_data.size() < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_eq("t5b_reach_beat5", 64'(got_data.size()), 64'd5);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t5b");
        repeat (6) @(posedge clk);
        check_eq("t5b_no_late_beat", 64'(got_data.size()), 64'd5);
        check_eq("t5b_no_done", 64'(done_cnt - done_base), 64'd0);
        start_xfer(32'h0000_0800, 16'd2);
        wait_done("t5c");
        verify("t5c", 32'h0000_0800, 2);

        // T6: address wrap
        start_xfer(32'hFFFF_FFF8, 16'd4);
        wait_done("t6");
        check_eq("t6_addr2", 64'(acc_addr[2]), 64'h0);
        check_eq("t6_addr3", 64'(acc_addr[3]), 64'h4);
        verify("t6", 32'hFFFF_FFF8, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
